zprize_mul_split: RTL and testbench
===================================

Name: zprize_mul_split

Overview:
- Fully pipelined W0 x W1 unsigned multiplier for the MSM datapath.
- Successor to the fixed two-limb 26/23 split multiplier: in0 is cut into NL limbs of LW bits, for any NL.
- Each limb is multiplied by in1; partial products are combined in a registered pairwise reduction tree.
- Adds in/out valid, a global clock-enable stall, and an M-bit sideband that stays aligned with the product.

Parameters:
- W0, 49, width of in0 (split operand)
- W1, 384, width of in1
- LW, 26, limb width; NL = ceil(W0/LW); last limb is W0-(NL-1)*LW bits wide
- M, 32, sideband width
- MUL_LAT, 3, latency of the limb multiplier sub-module, ≥1
- T, 32'h07F7_F999, DSP tiling code, passed unchanged to the limb multipliers

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ce  in  1  pipeline enable; 0 freezes every register
- in_valid  in  1  operands valid this cycle (sampled when ce=1)
- in0  in  W0  multiplicand, split into limbs
- in1  in  W1  multiplier
- m_i  in  M  sideband, travels with operands
- out_valid  out  1  out0/m_o hold a product
- out0  out  W0+W1  exact product in0*in1
- m_o  out  M  sideband delayed to match out0

Behaviour:
- TREE = clog2(NL), which is 0 when NL=1.
- LAT = MUL_LAT + TREE + 1, the +1 being the output register. Defaults: NL=2, LAT=5.
- Stage A, limbs:
  - limb j = in0[j*LW +: width_j] feeds zprize_mul_limb instance j, together with in1.
  - Product j is registered MUL_LAT cycles later.
- Stage B, tree: level k holds ceil(NL/2^(k+1)) registers.
  - Node i = P[2i] + (P[2i+1] << (LW*2^k)).
  - An odd trailing node passes through registered, unchanged.
  - Node widths grow to hold the exact sum; nothing is truncated before out0.
- Output: the final node is zero-extended or truncated to W0+W1. The exact product always fits.
- Valid and sideband:
  - A LAT-deep shift register of {valid, m} runs in lockstep with the data path.
  - m_o is forwarded even when valid=0; consumers gate on out_valid.
- ce=0: all data, valid and sideband registers hold, including inside zprize_mul_limb. Outputs stay stable; inputs are ignored.
- ce=1: every stage advances by one.
- Back-to-back: one operation accepted per ce=1 cycle. No bubbles are required.
- Reset: async assert clears every pipeline register, valid bit and sideband bit, so out_valid=0, out0=0, m_o=0. In-flight operations are dropped.
- First acceptance after reset: in_valid=1 and ce=1 on the first clk edge after rst deasserts.
- Output for an operation accepted at edge t: visible after the edge LAT ce-qualified cycles later.
- in_valid=0 cycles still advance data registers, which may carry garbage; only out_valid is authoritative.
- NL=1: tree bypassed, LAT = MUL_LAT + 1.
- Elaboration errors: LW > W0 forces NL=1 (allowed); LW=0 or MUL_LAT=0 is a fatal elaboration error.

Optional Feature:
- Macro: ZPRIZE_MUL_SPLIT_CNT_EN.
- With the macro defined:
  - Extra port cnt_o, out, 32 bits: count of cycles with out_valid=1 and ce=1.
  - The count saturates at 32'hFFFF_FFFF and resets to 0.
- Without it: no port, no counter logic.

Decomposition:
- Package zprize_mul_pkg holds:
  - function clog2
  - function mul_split_lat(W0, LW, MUL_LAT) returning LAT
  - function nl(W0, LW)
  - localparam defaults LW_DEF=26 and MUL_LAT_DEF=3
- One sub-module, zprize_mul_limb(W0=width_j, W1, T, LAT=MUL_LAT, ce):
  - parametrised LW x W1 DSP-tiled multiplier with a ce-gated internal pipeline
  - instantiated NL times via generate
- Reduction tree and valid/sideband shift register stay in the top level.

Test Plan:
- Max operands, defaults: in0=2^49-1, in1=2^384-1, m_i=32'hA5A5_0001, ce=1 → after 5 cycles out_valid=1, out0=(2^49-1)*(2^384-1), m_o=32'hA5A5_0001.
- Back-to-back random: 1000 random (in0, in1, m_i) with in_valid=1 every cycle → 1000 consecutive out_valid pulses with exact products, in order, sideband matched.
- Stall: issue in0=3, in1=5; hold ce=0 for 7 cycles at cycle 2 → out0=15 appears 5 ce=1 cycles after issue; out0/m_o/out_valid stable during the stall.
- Reset mid-flight: issue 3 ops, assert rst at cycle 2 → out_valid, out0, m_o all 0 immediately; none of the 3 ops ever emerges; the next op after release completes in 5 cycles.
- Config sweep:
  - W0=20 (NL=1, LAT=4): in0=20'hFFFFF, in1=7 → out0=20'hFFFFF*7 after 4 cycles.
  - W0=64, LW=26 (NL=3, LAT=6): in0=2^64-1, in1=2^384-1 → exact product after 6 cycles.
- Counter, with ZPRIZE_MUL_SPLIT_CNT_EN: 10 valid ops plus 4 bubbles → cnt_o=10; after rst → cnt_o=0.

Source files
------------

// File: rtl/zprize_mul_pkg.sv
// Shared helpers for the split multiplier: limb count, tree depth, pipeline latency and DSP tile selection.
package zprize_mul_pkg;

    typedef enum logic {
        TILE_18X17 = 1'b0,
        TILE_27X24 = 1'b1
    } tile_mode_e;

    localparam int LW_DEF      = 26;
    localparam int MUL_LAT_DEF = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int nl(input int w0, input int lw);
        if (lw <= 0) begin
            return 1;
        end
        return (w0 + lw - 1) / lw;
    endfunction

    function automatic int mul_split_lat(input int w0, input int lw, input int mul_lat);
        return mul_lat + clog2(nl(w0, lw)) + 1;
    endfunction

    // Bit 0 of the tiling code picks the wide 27x24 DSP shape; otherwise 18x17 tiles are used.
    function automatic tile_mode_e tile_mode(input logic t0);
        return tile_mode_e'(t0);
    endfunction

    function automatic int tile_w(input logic t0);
        return (tile_mode(t0) == TILE_27X24) ? 24 : 17;
    endfunction

endpackage

// File: rtl/zprize_mul_limb.sv
// One limb x W1 multiplier: in1 is cut into DSP-sized tiles, tile products are summed, LAT-register ce-gated pipeline.
module zprize_mul_limb
    import zprize_mul_pkg::*;
#(
    parameter int          W0  = LW_DEF,
    parameter int          W1  = 384,
    parameter logic [31:0] T   = 32'h07F7_F999,
    parameter int          LAT = MUL_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [W0-1:0]    a_i,
    input  logic [W1-1:0]    b_i,
    output logic [W0+W1-1:0] p_o
);

    localparam int TW    = tile_w(T[0]);
    localparam int NT    = (W1 + TW - 1) / TW;
    localparam int PW    = W0 + W1;
    localparam int TPW   = W0 + TW;
    localparam int SW    = W0 + NT * TW;
    localparam int NPROD = (LAT > 1) ? LAT - 1 : 1;

    logic [NT*TW-1:0] bExt;
    logic [TPW-1:0]   tileProd_d [NT];
    logic [TPW-1:0]   tileProd   [NT];
    logic [SW-1:0]    tileSum;
    logic [PW-1:0]    prod_q     [NPROD];

    assign bExt = (NT*TW)'(b_i);

    always_comb begin
        for (int t = 0; t < NT; t++) begin
            tileProd_d[t] = TPW'(a_i) * TPW'(bExt[t*TW +: TW]);
        end
    end

    // With a single-cycle budget the tiles feed the adder directly; otherwise they get their own register stage.
    generate
        if (LAT == 1) begin : g_comb_tiles
            always_comb begin
                for (int t = 0; t < NT; t++) begin
                    tileProd[t] = tileProd_d[t];
                end
            end
        end else begin : g_reg_tiles
            logic [TPW-1:0] tileProd_q [NT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int t = 0; t < NT; t++) begin
                        tileProd_q[t] <= '0;
                    end
                end else if (ce) begin
                    for (int t = 0; t < NT; t++) begin
                        tileProd_q[t] <= tileProd_d[t];
                    end
                end
            end

            always_comb begin
                for (int t = 0; t < NT; t++) begin
                    tileProd[t] = tileProd_q[t];
                end
            end
        end
    endgenerate

    always_comb begin
        tileSum = '0;
        for (int t = 0; t < NT; t++) begin
            tileSum = tileSum + (SW'(tileProd[t]) << (t * TW));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPROD; i++) begin
                prod_q[i] <= '0;
            end
        end else if (ce) begin
            prod_q[0] <= tileSum[PW-1:0];
            for (int i = 1; i < NPROD; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
        end
    end

    assign p_o = prod_q[NPROD-1];

endmodule

// File: rtl/zprize_mul_split.sv
// Pipelined W0 x W1 multiplier: in0 split into LW-bit limbs, registered pairwise reduction tree, aligned valid/sideband.
// Optional macro ZPRIZE_MUL_SPLIT_CNT_EN adds cnt_o, a saturating count of accepted output beats.
module zprize_mul_split
    import zprize_mul_pkg::*;
#(
    parameter int          W0      = 49,
    parameter int          W1      = 384,
    parameter int          LW      = LW_DEF,
    parameter int          M       = 32,
    parameter int          MUL_LAT = MUL_LAT_DEF,
    parameter logic [31:0] T       = 32'h07F7_F999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [W0-1:0]    in0,
    input  logic [W1-1:0]    in1,
    input  logic [M-1:0]     m_i,
    output logic             out_valid,
    output logic [W0+W1-1:0] out0,
    output logic [M-1:0]     m_o
`ifdef ZPRIZE_MUL_SPLIT_CNT_EN
    ,
    output logic [31:0]      cnt_o
`endif
);

    localparam int NL   = nl(W0, LW);
    localparam int TREE = clog2(NL);
    localparam int LAT  = mul_split_lat(W0, LW, MUL_LAT);
    localparam int PW   = W0 + W1;

    generate
        if (LW <= 0) begin : g_bad_lw
            $fatal(1, "zprize_mul_split: LW must be at least 1");
        end
        if (MUL_LAT <= 0) begin : g_bad_lat
            $fatal(1, "zprize_mul_split: MUL_LAT must be at least 1");
        end
    endgenerate

    // lvl[0] holds limb products, lvl[k+1] the registered nodes of tree level k; only the low entries of each level exist.
    logic [PW-1:0]  lvl [TREE+1][NL];
    logic [PW-1:0]  out0_q;
    logic [LAT-1:0] validPipe_q;
    logic [M-1:0]   sidePipe_q [LAT];

    generate
        for (genvar j = 0; j < NL; j++) begin : g_limb
            localparam int WJ = (j == NL - 1) ? W0 - (NL - 1) * LW : LW;
            logic [WJ+W1-1:0] limbOut;

            zprize_mul_limb #(
                .W0  (WJ),
                .W1  (W1),
                .T   (T),
                .LAT (MUL_LAT)
            ) u_limb (
                .clk (clk),
                .rst (rst),
                .ce  (ce),
                .a_i (in0[j*LW +: WJ]),
                .b_i (in1),
                .p_o (limbOut)
            );

            assign lvl[0][j] = PW'(limbOut);
        end

        for (genvar k = 0; k < TREE; k++) begin : g_lvl
            localparam int CIN  = (NL + (1 << k) - 1) >> k;
            localparam int COUT = (CIN + 1) / 2;
            logic [PW-1:0] node_d [COUT];
            logic [PW-1:0] node_q [COUT];

            for (genvar i = 0; i < COUT; i++) begin : g_node
                if (2 * i + 1 < CIN) begin : g_pair
                    assign node_d[i] = lvl[k][2*i] + (lvl[k][2*i+1] << (LW * (1 << k)));
                end else begin : g_pass
                    assign node_d[i] = lvl[k][2*i];
                end
                assign lvl[k+1][i] = node_q[i];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < COUT; i++) begin
                        node_q[i] <= '0;
                    end
                end else if (ce) begin
                    for (int i = 0; i < COUT; i++) begin
                        node_q[i] <= node_d[i];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0_q      <= '0;
            validPipe_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                sidePipe_q[i] <= '0;
            end
        end else if (ce) begin
            out0_q         <= lvl[TREE][0];
            validPipe_q[0] <= in_valid;
            sidePipe_q[0]  <= m_i;
            for (int i = 1; i < LAT; i++) begin
                validPipe_q[i] <= validPipe_q[i-1];
                sidePipe_q[i]  <= sidePipe_q[i-1];
            end
        end
    end

    assign out_valid = validPipe_q[LAT-1];
    assign out0      = out0_q;
    assign m_o       = sidePipe_q[LAT-1];

`ifdef ZPRIZE_MUL_SPLIT_CNT_EN
    logic [31:0] validCnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validCnt_q <= '0;
        end else if (ce && validPipe_q[LAT-1] && (validCnt_q != 32'hFFFF_FFFF)) begin
            validCnt_q <= validCnt_q + 32'd1;
        end
    end

    assign cnt_o = validCnt_q;
`endif

endmodule

// File: tb/tb_zprize_mul_split.sv
// Self-checking bench for zprize_mul_split: vector table, random back-to-back traffic against a queue model, stall/reset/config cases.
module tb_zprize_mul_split;

    localparam int LAT   = 5;
    localparam int LAT20 = 4;
    localparam int LAT64 = 6;

    typedef struct {
        logic [48:0]  in0;
        logic [383:0] in1;
        logic [31:0]  m;
        logic [432:0] expProd;
    } vec_t;

    typedef struct {
        int unsigned  due;
        logic [432:0] prod;
        logic [31:0]  m;
    } pend_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ce = 1'b1;
    logic         in_valid = 1'b0;
    logic [48:0]  in0 = '0;
    logic [383:0] in1 = '0;
    logic [31:0]  m_i = '0;
    logic         out_valid;
    logic [432:0] out0;
    logic [31:0]  m_o;

    logic         valid20 = 1'b0;
    logic [19:0]  in0_20 = '0;
    logic [383:0] in1_20 = '0;
    logic [31:0]  m20 = '0;
    logic         out_valid20;
    logic [403:0] out0_20;
    logic [31:0]  m_o20;

    logic         valid64 = 1'b0;
    logic [63:0]  in0_64 = '0;
    logic [383:0] in1_64 = '0;
    logic [31:0]  m64 = '0;
    logic         out_valid64;
    logic [447:0] out0_64;
    logic [31:0]  m_o64;

`ifdef ZPRIZE_MUL_SPLIT_CNT_EN
    logic [31:0]  cnt;
    logic [31:0]  cnt20;
    logic [31:0]  cnt64;
`endif

    int checks = 0;
    int errors = 0;
    int validSeen = 0;
    int unsigned ceCount = 0;
    pend_t pending[$];

    always #5 clk = ~clk;

    zprize_mul_split u_dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in0       (in0),
        .in1       (in1),
        .m_i       (m_i),
        .out_valid (out_valid),
        .out0      (out0),
        .m_o       (m_o)
`ifdef ZPRIZE_MUL_SPLIT_CNT_EN
        ,
        .cnt_o     (cnt)
`endif
    );

    zprize_mul_split #(.W0(20)) u_dut20 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (valid20),
        .in0       (in0_20),
        .in1       (in1_20),
        .m_i       (m20),
        .out_valid (out_valid20),
        .out0      (out0_20),
        .m_o       (m_o20)
`ifdef ZPRIZE_MUL_SPLIT_CNT_EN
        ,
        .cnt_o     (cnt20)
`endif
    );

    zprize_mul_split #(.W0(64)) u_dut64 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (valid64),
        .in0       (in0_64),
        .in1       (in1_64),
        .m_i       (m64),
        .out_valid (out_valid64),
        .out0      (out0_64),
        .m_o       (m_o64)
`ifdef ZPRIZE_MUL_SPLIT_CNT_EN
        ,
        .cnt_o     (cnt64)
`endif
    );

    task automatic checkVal(input string name, input logic [511:0] act, input logic [511:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic [48:0] a, input logic [383:0] b, input logic [31:0] m, input logic v);
        in0      = a;
        in1      = b;
        m_i      = m;
        in_valid = v;
    endtask

    // Model: an accepted op is due LAT ce-qualified edges after it enters, counting the accepting edge.
    task automatic checkOutput();
        logic expValid;
        while (pending.size() > 0 && pending[0].due < ceCount) begin
            void'(pending.pop_front());
        end
        expValid = !rst && pending.size() > 0 && pending[0].due == ceCount;
        if (out_valid === 1'b1) validSeen++;
        checkVal("model out_valid", out_valid, expValid);
        if (rst) begin
            checkVal("reset out0", out0, '0);
            checkVal("reset m_o", m_o, '0);
        end else if (expValid) begin
            checkVal("model out0", out0, pending[0].prod);
            checkVal("model m_o", m_o, pending[0].m);
        end
    endtask

    task automatic stepCycle();
        logic [432:0] p;
        @(posedge clk);
        if (rst) begin
            pending.delete();
        end else if (ce) begin
            ceCount++;
            if (in_valid) begin
                p = 433'(in0) * 433'(in1);
                pending.push_back('{due: ceCount + LAT - 1, prod: p, m: m_i});
            end
        end
        #1;
        checkOutput();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t         vecs [7];
        logic [432:0] one433;
        logic [447:0] one448;
        logic [383:0] pat;

        one433 = 433'(1);
        one448 = 448'(1);
        pat    = {12{32'hC0FF_EE11}};

        vecs[0] = '{in0: {49{1'b1}}, in1: {384{1'b1}}, m: 32'hA5A5_0001,
                    expProd: {433{1'b1}} - (one433 << 384) - (one433 << 49) + 433'd2};
        vecs[1] = '{in0: 49'd3, in1: 384'd5, m: 32'h0000_0001, expProd: 433'd15};
        vecs[2] = '{in0: 49'd0, in1: {384{1'b1}}, m: 32'h0000_0002, expProd: 433'd0};
        vecs[3] = '{in0: 49'd1, in1: pat, m: 32'h0000_0003, expProd: 433'(pat)};
        vecs[4] = '{in0: 49'(one433 << 48), in1: 384'd1, m: 32'h0000_0004, expProd: one433 << 48};
        vecs[5] = '{in0: 49'(one433 << 26), in1: 384'(one433 << 383), m: 32'h0000_0005, expProd: one433 << 409};
        vecs[6] = '{in0: 49'h3FF_FFFF, in1: 384'd2, m: 32'h0000_0006, expProd: (one433 << 27) - 433'd2};

        // Power-on reset.
        rst = 1'b1;
        stepCycle();
        stepCycle();
        checkVal("reset out_valid", out_valid, 1'b0);
        rst = 1'b0;

        // Table vectors, one at a time.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].in0, vecs[v].in1, vecs[v].m, 1'b1);
            stepCycle();
            applyStimulus('0, '0, '0, 1'b0);
            repeat (LAT - 2) stepCycle();
            checkVal("vec early out_valid", out_valid, 1'b0);
            stepCycle();
            checkVal("vec out_valid", out_valid, 1'b1);
            checkVal("vec out0", out0, vecs[v].expProd);
            checkVal("vec m_o", m_o, vecs[v].m);
        end

        // Stall mid-flight, then stall while the result is presented.
        applyStimulus(49'd3, 384'd5, 32'h0000_5700, 1'b1);
        stepCycle();
        applyStimulus('0, '0, '0, 1'b0);
        stepCycle();
        ce = 1'b0;
        applyStimulus(49'd7, 384'd9, 32'hDEAD_0000, 1'b1);
        repeat (7) stepCycle();
        applyStimulus('0, '0, '0, 1'b0);
        ce = 1'b1;
        repeat (LAT - 2) stepCycle();
        checkVal("stall out_valid", out_valid, 1'b1);
        checkVal("stall out0", out0, 433'd15);
        checkVal("stall m_o", m_o, 32'h0000_5700);
        ce = 1'b0;
        repeat (3) stepCycle();
        checkVal("held out0", out0, 433'd15);
        ce = 1'b1;
        stepCycle();
        checkVal("after hold out_valid", out_valid, 1'b0);

        // Random back-to-back traffic.
        validSeen = 0;
        for (int n = 0; n < 1000; n++) begin
            logic [383:0] r1;
            logic [48:0]  r0;
            for (int w = 0; w < 12; w++) r1[w*32 +: 32] = $urandom();
            r0 = 49'({$urandom(), $urandom()});
            if (n % 97 == 0) begin
                r0 = {49{1'b1}};
                r1 = {384{1'b1}};
            end
            applyStimulus(r0, r1, $urandom(), 1'b1);
            stepCycle();
        end
        applyStimulus('0, '0, '0, 1'b0);
        repeat (LAT + 1) stepCycle();
        checkVal("random pulse count", 32'(validSeen), 32'd1000);

        // Asynchronous reset with three operations in flight.
        applyStimulus(49'd11, 384'd13, 32'h1111_1111, 1'b1);
        stepCycle();
        applyStimulus(49'd17, 384'd19, 32'h2222_2222, 1'b1);
        stepCycle();
        applyStimulus(49'd23, 384'd29, 32'h3333_3333, 1'b1);
        stepCycle();
        #2;
        rst = 1'b1;
        pending.delete();
        #1;
        checkVal("async rst out_valid", out_valid, 1'b0);
        checkVal("async rst out0", out0, '0);
        checkVal("async rst m_o", m_o, '0);
        repeat (2) stepCycle();
        rst = 1'b0;
        applyStimulus(49'd100, 384'd200, 32'h4444_4444, 1'b1);
        stepCycle();
        applyStimulus('0, '0, '0, 1'b0);
        repeat (LAT - 1) stepCycle();
        checkVal("post rst out_valid", out_valid, 1'b1);
        checkVal("post rst out0", out0, 433'd20000);
        checkVal("post rst m_o", m_o, 32'h4444_4444);
        repeat (3) stepCycle();

        // Single-limb configuration.
        in0_20  = 20'hFFFFF;
        in1_20  = 384'd7;
        m20     = 32'h0000_2020;
        valid20 = 1'b1;
        stepCycle();
        valid20 = 1'b0;
        in0_20  = '0;
        in1_20  = '0;
        m20     = '0;
        repeat (LAT20 - 2) stepCycle();
        checkVal("w20 early out_valid", out_valid20, 1'b0);
        stepCycle();
        checkVal("w20 out_valid", out_valid20, 1'b1);
        checkVal("w20 out0", out0_20, 404'h6F_FFF9);
        checkVal("w20 m_o", m_o20, 32'h0000_2020);

        // Three-limb configuration.
        in0_64  = {64{1'b1}};
        in1_64  = {384{1'b1}};
        m64     = 32'h0000_6464;
        valid64 = 1'b1;
        stepCycle();
        valid64 = 1'b0;
        in0_64  = '0;
        in1_64  = '0;
        m64     = '0;
        repeat (LAT64 - 2) stepCycle();
        checkVal("w64 early out_valid", out_valid64, 1'b0);
        stepCycle();
        checkVal("w64 out_valid", out_valid64, 1'b1);
        checkVal("w64 out0", out0_64, {448{1'b1}} - (one448 << 384) - (one448 << 64) + 448'd2);
        checkVal("w64 m_o", m_o64, 32'h0000_6464);

`ifdef ZPRIZE_MUL_SPLIT_CNT_EN
        rst = 1'b1;
        stepCycle();
        checkVal("cnt after reset", cnt, 32'd0);
        rst = 1'b0;
        for (int n = 0; n < 14; n++) begin
            if (n == 3 || n == 6 || n == 9 || n == 12) applyStimulus('0, '0, '0, 1'b0);
            else applyStimulus(49'(n + 1), 384'(n + 2), 32'(n), 1'b1);
            stepCycle();
        end
        applyStimulus('0, '0, '0, 1'b0);
        repeat (LAT + 2) stepCycle();
        checkVal("cnt ten ops", cnt, 32'd10);
        #2;
        rst = 1'b1;
        pending.delete();
        #1;
        checkVal("cnt async rst", cnt, 32'd0);
        stepCycle();
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
